// File: rtl/chip_counter_chk.sv
// Functional checker for 74161/74163 counter slices (single or cascaded up to 16 bits).
// Define CHIP_CHK_ERRLOG_EN to build the first-failure capture registers behind ErrPhase/ErrExp/ErrAct.
module chip_counter_chk #(
   parameter int WIDTH    = 4,
   parameter int SYNC_CLR = 0,
   parameter int SETTLE   = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Run,
   output logic             DutClk,
   output logic             DutClrN,
   output logic             DutLoadN,
   output logic             DutEnP,
   output logic             DutEnT,
   output logic [WIDTH-1:0] DutD,
   input  logic [WIDTH-1:0] DutQ,
   input  logic             DutRco,
   output logic             Done,
   output logic             RSLT,
   input  logic             DISP_RSLT,
   output logic [2:0]       ErrPhase,
   output logic [WIDTH-1:0] ErrExp,
   output logic [WIDTH-1:0] ErrAct
);

   localparam int               CNT_W    = (SETTLE > 2) ? $clog2(SETTLE) : 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] PATTERN  = {(WIDTH / 4){4'hA}};
   localparam logic [WIDTH-1:0] LOAD2_D  = ALL_ONES - WIDTH'(1);

   // State encodings double as the phase codes reported on ErrPhase.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD1  = 3'd1,
      CLR    = 3'd2,
      COUNT  = 3'd3,
      LOAD2  = 3'd4,
      HOLD_P = 3'd5,
      HOLD_T = 3'd6,
      DONE   = 3'd7
   } state_t;

   typedef struct packed {
      logic             clr_n;
      logic             load_n;
      logic             en_p;
      logic             en_t;
      logic [WIDTH-1:0] d;
   } pins_t;

   function automatic pins_t step_pins(input state_t s);
      pins_t p;
      p.clr_n  = 1'b1;
      p.load_n = 1'b1;
      p.en_p   = 1'b0;
      p.en_t   = 1'b0;
      p.d      = '0;
      case (s)
         LOAD1:   begin p.load_n = 1'b0; p.d = PATTERN; end
         CLR:     p.clr_n = 1'b0;
         COUNT:   begin p.en_p = 1'b1; p.en_t = 1'b1; end
         LOAD2:   begin p.load_n = 1'b0; p.d = LOAD2_D; end
         HOLD_P:  p.en_t = 1'b1;
         HOLD_T:  p.en_p = 1'b1;
         default: ;
      endcase
      return p;
   endfunction

   function automatic state_t next_step(input state_t s, input logic wrapped);
      state_t n;
      case (s)
         LOAD1:   n = CLR;
         CLR:     n = COUNT;
         COUNT:   n = wrapped ? LOAD2 : COUNT;
         LOAD2:   n = HOLD_P;
         HOLD_P:  n = HOLD_T;
         default: n = DONE;
      endcase
      return n;
   endfunction

   state_t           state;
   state_t           nxt;
   logic             phase_b;
   logic [CNT_W-1:0] cnt;
   logic             phase_end;
   logic             pass;
   logic             done_p0;
   logic             done_p1;
   logic [WIDTH-1:0] q_model;
   logic [WIDTH-1:0] q_p0;
   logic [WIDTH-1:0] q_p1;
   logic             rco_p0;
   logic             rco_p1;
   logic [WIDTH-1:0] exp_q;
   logic             exp_rco;
   logic             chk_en;
   logic             mismatch;

   // p0 -> p1: two-flop synchroniser for the asynchronous DUT outputs
   always_ff @(posedge Clk) begin
      q_p0   <= DutQ;
      q_p1   <= q_p0;
      rco_p0 <= DutRco;
      rco_p1 <= rco_p0;
   end

   always_comb begin
      exp_q  = q_model;
      chk_en = 1'b0;
      case (state)
         LOAD1:          begin exp_q = PATTERN; chk_en = phase_b; end
         CLR:            begin
                            exp_q  = (SYNC_CLR != 0 && !phase_b) ? PATTERN : '0;
                            chk_en = 1'b1;
                         end
         COUNT:          begin exp_q = q_model + WIDTH'(1); chk_en = phase_b; end
         LOAD2:          begin exp_q = LOAD2_D; chk_en = phase_b; end
         HOLD_P, HOLD_T: chk_en = phase_b;
         default:        ;
      endcase
      exp_rco   = DutEnT & (exp_q == ALL_ONES);
      phase_end = (cnt == CNT_LAST);
      mismatch  = chk_en && phase_end &&
                  ((q_p1 != exp_q) || (phase_b && (rco_p1 != exp_rco)));
      nxt       = next_step(state, exp_q == '0);
   end

   // Model of the DUT count, advanced at the end of every clocked half-phase.
   always_ff @(posedge Clk) begin
      if (phase_b && phase_end)
         q_model <= exp_q;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         phase_b <= 1'b0;
         cnt     <= '0;
         pass    <= 1'b0;
         done_p0 <= 1'b0;
         done_p1 <= 1'b0;
         DutClk  <= 1'b0;
         {DutClrN, DutLoadN, DutEnP, DutEnT, DutD} <= step_pins(IDLE);
      end else begin
         done_p0 <= (state == DONE);
         done_p1 <= done_p0;
         case (state)
            IDLE: begin
               if (Run) begin
                  state   <= LOAD1;
                  phase_b <= 1'b0;
                  cnt     <= '0;
                  pass    <= 1'b1;
                  {DutClrN, DutLoadN, DutEnP, DutEnT, DutD} <= step_pins(LOAD1);
               end
            end
            DONE: begin
               if (!Run) begin
                  state   <= IDLE;
                  pass    <= 1'b0;
                  done_p0 <= 1'b0;
                  done_p1 <= 1'b0;
               end
            end
            default: begin
               if (!phase_end) begin
                  cnt <= cnt + CNT_W'(1);
               end else begin
                  cnt <= '0;
                  // A failure parks the pins at rest so the DUT sees no further rising edge.
                  if (mismatch) begin
                     state   <= DONE;
                     pass    <= 1'b0;
                     phase_b <= 1'b0;
                     DutClk  <= 1'b0;
                     {DutClrN, DutLoadN, DutEnP, DutEnT, DutD} <= step_pins(DONE);
                  end else if (!phase_b) begin
                     phase_b <= 1'b1;
                     DutClk  <= 1'b1;
                  end else begin
                     phase_b <= 1'b0;
                     DutClk  <= 1'b0;
                     state   <= nxt;
                     {DutClrN, DutLoadN, DutEnP, DutEnT, DutD} <= step_pins(nxt);
                  end
               end
            end
         endcase
      end
   end

   assign Done = done_p1;
   assign RSLT = pass & done_p1 & DISP_RSLT;

`ifdef CHIP_CHK_ERRLOG_EN
   logic [2:0]       err_phase;
   logic [WIDTH-1:0] err_exp;
   logic [WIDTH-1:0] err_act;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         err_phase <= '0;
         err_exp   <= '0;
         err_act   <= '0;
      end else if (state == DONE && !Run) begin
         err_phase <= '0;
         err_exp   <= '0;
         err_act   <= '0;
      end else if (mismatch) begin
         err_phase <= state;
         err_exp   <= exp_q;
         err_act   <= q_p1;
      end
   end

   assign ErrPhase = err_phase;
   assign ErrExp   = err_exp;
   assign ErrAct   = err_act;
`else
   assign ErrPhase = '0;
   assign ErrExp   = '0;
   assign ErrAct   = '0;
`endif

endmodule
